inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage: owns the PC, fetches 32-bit instruction words from the memory controller over a request/ready handshake, and presents `{pc, inst}` to the IF/ID pipeline register, one word per cycle on cache hits. It sits directly upstream of decode. It accepts redirects (JAL from decode; branch/JALR from execute) and pipeline stalls. An optional direct-mapped instruction cache is compiled in with a macro.

## Interface
Parameters:
- `ADDR_W`, 32, PC / memory address width.
- `RESET_PC`, 32'h0, PC value after reset.
- `ICACHE_ENTRIES`, 64, cache lines (power of two, one word each); ignored without the macro.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  downstream cannot accept the presented instruction this cycle.
- `jump_enable_i`  in  1  redirect request, one-cycle pulse.
- `jump_pc_i`  in  ADDR_W  redirect target.
- `inst_req_o`  out  1  fetch request to memory controller.
- `inst_addr_o`  out  ADDR_W  fetch word address; bits [1:0] always 0.
- `inst_ready_i`  in  1  one-cycle pulse: `inst_data_i` valid for the outstanding request.
- `inst_data_i`  in  32  fetched word.
- `inst_valid_o`  out  1  `pc_o`/`inst_o` hold a valid instruction.
- `pc_o`  out  ADDR_W  address of presented instruction.
- `inst_o`  out  32  presented instruction.

## Operation
- Registers: `pc` (next address to fetch), `fetch_addr`, output register `{valid, pc_o, inst_o}`, one-entry skid `{skid_v, skid_pc, skid_inst}`, state.
- Output consumed when `inst_valid_o && !stall_i`. The output register may load only when empty or consumed the same cycle; otherwise the word goes to the skid.
- States:
  - S_REQ: on hit with output free, load output from cache, `pc <= pc+4`, stay. On miss, `fetch_addr <= pc`, go to S_WAIT. On hit with output full, stay idle.
  - S_WAIT: `inst_req_o=1`, `inst_addr_o=fetch_addr`. On `inst_ready_i`: fill cache, `pc <= pc+4`. If output free, load output and go to S_REQ; else load skid and go to S_HOLD.
  - S_HOLD: no request. When output consumed, skid moves to output, `skid_v<=0`, go to S_REQ.
  - S_DROP: `inst_req_o=1` on stale `fetch_addr`. On `inst_ready_i`, fill cache, discard data, go to S_REQ.
- Memory-controller rule: once asserted, `inst_req_o` and `inst_addr_o` stay stable until `inst_ready_i`. A request is never withdrawn.
- Redirect (`jump_enable_i`) has top priority in every state:
  - `pc <= jump_pc_i`, with bits [1:0] forced to 0.
  - Output valid cleared, skid cleared.
  - From S_WAIT without `inst_ready_i`, go to S_DROP. Otherwise go to S_REQ.
  - Redirect in the same cycle as `inst_ready_i`: cache filled, data discarded.
  - Redirect during S_DROP: `pc` updated, stay in S_DROP.
- PC arithmetic is modulo 2^ADDR_W: `pc+4` at the top address wraps to 0.
- Cache: index = `pc[IDX+1:2]` with IDX = log2(ICACHE_ENTRIES). Tag = `pc[ADDR_W-1:IDX+2]`. One valid bit per line. Hit = valid && tag match.

## Timing
- Reset (async, `rst_n` low): `pc=RESET_PC`, state S_REQ, `inst_valid_o=0`, `pc_o=0`, `inst_o=0`, `inst_req_o=0`, `inst_addr_o=0`, `skid_v=0`, all cache valid bits 0.
- Reset mid-request: request dropped; the memory controller is reset by the same `rst_n`.
- Hit latency: `inst_valid_o` rises 1 cycle after the address is in `pc`. Hit throughput is 1 instruction/cycle with no stall.
- Miss: `inst_req_o` rises 1 cycle after detection. Output is valid the cycle after `inst_ready_i`.
- `inst_req_o` and `inst_addr_o` are registered outputs, asserted only in S_WAIT/S_DROP.
- Under `stall_i`, `inst_valid_o`/`pc_o`/`inst_o` hold unchanged.

## Configuration
- `INST_FETCH_ICACHE_EN` defined: cache present, behaviour as above.
- Not defined: no cache storage; every fetch misses. Cycle is S_REQ→S_WAIT every instruction, so throughput is 1 per (2 + memory latency) cycles. Parameter `ICACHE_ENTRIES` is unused. All other behaviour is identical.

## Test plan
- Reset release, memory latency 3, no stall: first `inst_req_o` at cycle 1 with addr 0x0. `inst_valid_o=1, pc_o=0x0` the cycle after `inst_ready_i`. Next request addr 0x4.
- Loop 0x0–0xC executed twice (cache on): second pass issues no `inst_req_o`, output is 1 instr/cycle, `pc_o` = 0x0, 0x4, 0x8, 0xC.
- `stall_i=1` for 5 cycles while a miss returns: output unchanged throughout. Skid holds the next word, which appears the cycle after `stall_i` drops. No word is lost or duplicated.
- `jump_enable_i`, `jump_pc_i=0x100` during S_WAIT for addr 0x8: `inst_req_o`/addr 0x8 held until ready, 0x8 data never output. Next request is 0x100, and `inst_valid_o=0` until 0x100 arrives.
- Jump coincident with `inst_ready_i`: returned word discarded, cache line filled. Next `pc_o` is the jump target.
- `rst_n` asserted mid-S_WAIT: all outputs return to reset values immediately. After release, fetch restarts at RESET_PC with the cache empty.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready handshake and
// presents {pc, inst} downstream. Define INST_FETCH_ICACHE_EN to add a direct-mapped I-cache.
module inst_fetch #(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                ICACHE_ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              jump_enable_i,
  input  logic [ADDR_W-1:0] jump_pc_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i,
  input  logic [31:0]       inst_data_i,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_addr;
  logic              skid_v;
  logic [ADDR_W-1:0] skid_pc;
  logic [31:0]       skid_inst;

  logic              consumed;
  logic              out_free;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] jump_target;
  logic              hit;
  logic [31:0]       hit_data;

  assign consumed    = inst_valid_o && !stall_i;
  assign out_free    = !inst_valid_o || !stall_i;
  assign pc_next     = pc + ADDR_W'(4);
  assign jump_target = {jump_pc_i[ADDR_W-1:2], 2'b00};

`ifdef INST_FETCH_ICACHE_EN
  localparam int IDX   = $clog2(ICACHE_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX - 2;

  logic [ICACHE_ENTRIES-1:0] line_v;
  logic [TAG_W-1:0]          line_tag  [ICACHE_ENTRIES];
  logic [31:0]               line_data [ICACHE_ENTRIES];
  logic [IDX-1:0]            rd_idx;
  logic [IDX-1:0]            wr_idx;
  logic                      fill;

  assign rd_idx   = pc[IDX+1:2];
  assign wr_idx   = fetch_addr[IDX+1:2];
  assign hit      = line_v[rd_idx] && (line_tag[rd_idx] == pc[ADDR_W-1:IDX+2]);
  assign hit_data = line_data[rd_idx];
  // Every returned word fills its line, including ones discarded by a redirect.
  assign fill     = inst_ready_i && ((state == S_WAIT) || (state == S_DROP));

  // NOTE: only the valid bits are reset; tag/data behave as plain RAM and are never read
  // while their line is invalid, so resetting them would only cost flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    line_v         <= '0;
    else if (fill) line_v[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag[wr_idx]  <= fetch_addr[ADDR_W-1:IDX+2];
      line_data[wr_idx] <= inst_data_i;
    end
  end
`else
  localparam int unused_icache_entries = ICACHE_ENTRIES;

  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // NOTE: all state here uses non-blocking assignments so every branch reads the
  // pre-edge values; later assignments in the block override the consume default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      fetch_addr   <= '0;
      inst_req_o   <= 1'b0;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
      pc_o         <= '0;
      inst_o       <= '0;
      skid_v       <= 1'b0;
      skid_pc      <= '0;
      skid_inst    <= '0;
    end else begin
      if (consumed) inst_valid_o <= 1'b0;

      if (jump_enable_i) begin
        pc           <= jump_target;
        inst_valid_o <= 1'b0;
        skid_v       <= 1'b0;
        if ((state == S_WAIT) || (state == S_DROP)) begin
          // A request in flight cannot be withdrawn; wait it out in S_DROP.
          if (inst_ready_i) begin
            inst_req_o <= 1'b0;
            state      <= S_REQ;
          end else begin
            state <= S_DROP;
          end
        end else begin
          state <= S_REQ;
        end
      end else begin
        case (state)
          S_REQ: begin
            if (hit) begin
              if (out_free) begin
                inst_valid_o <= 1'b1;
                pc_o         <= pc;
                inst_o       <= hit_data;
                pc           <= pc_next;
              end
            end else begin
              fetch_addr  <= pc;
              inst_req_o  <= 1'b1;
              inst_addr_o <= pc;
              state       <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (inst_ready_i) begin
              pc         <= pc_next;
              inst_req_o <= 1'b0;
              if (out_free) begin
                inst_valid_o <= 1'b1;
                pc_o         <= fetch_addr;
                inst_o       <= inst_data_i;
                state        <= S_REQ;
              end else begin
                skid_v    <= 1'b1;
                skid_pc   <= fetch_addr;
                skid_inst <= inst_data_i;
                state     <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (consumed && skid_v) begin
              inst_valid_o <= 1'b1;
              pc_o         <= skid_pc;
              inst_o       <= skid_inst;
              skid_v       <= 1'b0;
              state        <= S_REQ;
            end
          end
          S_DROP: begin
            if (inst_ready_i) begin
              inst_req_o <= 1'b0;
              state      <= S_REQ;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random stall/jump/latency traffic,
// checked against an instruction-stream model and a memory-protocol monitor.
module tb_inst_fetch;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        jump_enable_i = 1'b0;
  logic [31:0] jump_pc_i = '0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_data_i = 32'hDEAD_BEEF;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  int n_checks = 0;
  int n_fail = 0;
  int n_consumed = 0;

  bit rand_lat = 1'b0;
  int fixed_lat = 3;
  int cur_lat = 3;
  int mem_cnt = 0;

  inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .ICACHE_ENTRIES(64)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .jump_enable_i(jump_enable_i),
    .jump_pc_i(jump_pc_i), .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i), .inst_data_i(inst_data_i), .inst_valid_o(inst_valid_o),
    .pc_o(pc_o), .inst_o(inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory controller: ready pulses once the request has been seen for cur_lat cycles.
  initial forever begin
    @(negedge clk);
    if (!rst_n || !inst_req_o) begin
      mem_cnt      = 0;
      inst_ready_i = 1'b0;
      inst_data_i  = 32'hDEAD_BEEF;
    end else begin
      mem_cnt++;
      if (mem_cnt >= cur_lat) begin
        inst_ready_i = 1'b1;
        inst_data_i  = mem_word(inst_addr_o);
        mem_cnt      = 0;
        cur_lat      = rand_lat ? int'($urandom_range(4, 1)) : fixed_lat;
      end else begin
        inst_ready_i = 1'b0;
        inst_data_i  = 32'hDEAD_BEEF;
      end
    end
  end

  // Stream model: consumed words follow program order from RESET_PC or the last jump,
  // each carrying mem_word(pc); plus request stability and stall-hold rules.
  initial begin
    logic [31:0] exp_pc;
    bit          have_prev;
    logic        prev_req, prev_ready, prev_valid, prev_stall, prev_jump;
    logic [31:0] prev_addr, prev_pc, prev_inst;
    exp_pc    = RESET_PC;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_pc    = RESET_PC;
        have_prev = 1'b0;
        continue;
      end
      if (inst_req_o) check("addr_align", {30'b0, inst_addr_o[1:0]}, 32'h0);
      if (have_prev && prev_req && !prev_ready) begin
        check("req_stable", inst_req_o, 1);
        check("addr_stable", inst_addr_o, prev_addr);
      end
      if (have_prev && prev_valid && prev_stall && !prev_jump) begin
        check("hold_valid", inst_valid_o, 1);
        check("hold_pc", pc_o, prev_pc);
        check("hold_inst", inst_o, prev_inst);
      end
      if (inst_valid_o && !stall_i) begin
        check("stream_pc", pc_o, exp_pc);
        check("stream_inst", inst_o, mem_word(pc_o));
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (jump_enable_i) exp_pc = {jump_pc_i[31:2], 2'b00};
      prev_req   = inst_req_o;
      prev_ready = inst_ready_i;
      prev_addr  = inst_addr_o;
      prev_valid = inst_valid_o;
      prev_stall = stall_i;
      prev_jump  = jump_enable_i;
      prev_pc    = pc_o;
      prev_inst  = inst_o;
      have_prev  = 1'b1;
    end
  end

  initial begin
    #500_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int base_consumed;

    // Reset values
    tick();
    tick();
    check("rst_valid", inst_valid_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_req", inst_req_o, 0);
    check("rst_addr", inst_addr_o, 0);
    rst_n = 1'b1;

    // First fetch, latency 3
    tick();
    check("first_req", inst_req_o, 1);
    check("first_addr", inst_addr_o, 32'h0);
    check("first_valid", inst_valid_o, 0);
    tick();
    tick();
    check("first_ready", inst_ready_i, 1);
    tick();
    check("first_out_valid", inst_valid_o, 1);
    check("first_out_pc", pc_o, 32'h0);
    check("first_out_inst", inst_o, mem_word(32'h0));
    tick();
    check("second_req", inst_req_o, 1);
    check("second_addr", inst_addr_o, 32'h4);

    // Loop 0x0-0xC twice
    t = 0;
    while (!(inst_valid_o && pc_o == 32'hC) && t < 60) begin tick(); t++; end
    check("wait_pc_c", t < 60, 1);
    jump_enable_i = 1'b1;
    jump_pc_i     = 32'h0;
    tick();
    jump_enable_i = 1'b0;
    check("loop_jump_valid", inst_valid_o, 0);
    check("loop_jump_req", inst_req_o, 0);
`ifdef INST_FETCH_ICACHE_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check("loop_hit_valid", inst_valid_o, 1);
      check("loop_hit_pc", pc_o, 32'(i * 4));
      check("loop_hit_noreq", inst_req_o, 0);
    end
`else
    tick();
    check("loop_miss_req", inst_req_o, 1);
    check("loop_miss_addr", inst_addr_o, 32'h0);
`endif

    // Stall for 5 cycles while the 0x14 miss returns into the skid
    t = 0;
    while (!(inst_ready_i && inst_addr_o == 32'h10) && t < 60) begin tick(); t++; end
    check("wait_ready_10", t < 60, 1);
    tick();
    check("stall_start_pc", pc_o, 32'h10);
    check("stall_start_valid", inst_valid_o, 1);
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", inst_valid_o, 1);
      check("stall_pc", pc_o, 32'h10);
      check("stall_inst", inst_o, mem_word(32'h10));
    end
    stall_i = 1'b0;
    tick();
    check("skid_valid", inst_valid_o, 1);
    check("skid_pc", pc_o, 32'h14);
    check("skid_inst", inst_o, mem_word(32'h14));

    // Reset in the middle of a request
    t = 0;
    while (!inst_req_o && t < 30) begin tick(); t++; end
    check("wait_req_rst", t < 30, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", inst_valid_o, 0);
    check("midrst_pc", pc_o, 0);
    check("midrst_inst", inst_o, 0);
    check("midrst_req", inst_req_o, 0);
    check("midrst_addr", inst_addr_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("restart_req", inst_req_o, 1);
    check("restart_addr", inst_addr_o, RESET_PC);
    check("restart_valid", inst_valid_o, 0);

    // Jump while waiting on 0x8
    t = 0;
    while (!(inst_req_o && inst_addr_o == 32'h8) && t < 60) begin tick(); t++; end
    check("wait_req_8", t < 60, 1);
    jump_enable_i = 1'b1;
    jump_pc_i     = 32'h100;
    tick();
    jump_enable_i = 1'b0;
    check("drop_req", inst_req_o, 1);
    check("drop_addr", inst_addr_o, 32'h8);
    check("drop_valid", inst_valid_o, 0);
    t = 0;
    while (!inst_ready_i && t < 10) begin
      tick();
      t++;
      check("drop_hold_req", inst_req_o, 1);
      check("drop_hold_addr", inst_addr_o, 32'h8);
      check("drop_hold_valid", inst_valid_o, 0);
    end
    check("wait_drop_ready", t < 10, 1);
    tick();
    check("after_drop_valid", inst_valid_o, 0);
    check("after_drop_req", inst_req_o, 0);
    tick();
    check("target_req", inst_req_o, 1);
    check("target_addr", inst_addr_o, 32'h100);
    t = 0;
    while (!inst_valid_o && t < 10) begin tick(); t++; end
    check("wait_target_valid", t < 10, 1);
    check("target_pc", pc_o, 32'h100);
    check("target_inst", inst_o, mem_word(32'h100));

    // Jump coincident with ready for 0x104
    t = 0;
    while (!inst_ready_i && t < 10) begin tick(); t++; end
    check("wait_ready_104", t < 10, 1);
    check("ready_104_addr", inst_addr_o, 32'h104);
    jump_enable_i = 1'b1;
    jump_pc_i     = 32'h200;
    tick();
    jump_enable_i = 1'b0;
    check("coinc_valid", inst_valid_o, 0);
    check("coinc_req", inst_req_o, 0);
    t = 0;
    while (!inst_valid_o && t < 20) begin tick(); t++; end
    check("wait_200", t < 20, 1);
    check("coinc_pc", pc_o, 32'h200);
    jump_enable_i = 1'b1;
    jump_pc_i     = 32'h104;
    tick();
    jump_enable_i = 1'b0;
    check("refetch_104_req0", inst_req_o, 0);
    check("refetch_104_valid0", inst_valid_o, 0);
    tick();
`ifdef INST_FETCH_ICACHE_EN
    check("filled_104_valid", inst_valid_o, 1);
    check("filled_104_pc", pc_o, 32'h104);
    check("filled_104_noreq", inst_req_o, 0);
`else
    check("nocache_104_req", inst_req_o, 1);
    check("nocache_104_addr", inst_addr_o, 32'h104);
`endif

    // PC wrap; low target bits are ignored
    jump_enable_i = 1'b1;
    jump_pc_i     = 32'hFFFF_FFFE;
    tick();
    jump_enable_i = 1'b0;
    t = 0;
    while (!inst_valid_o && t < 20) begin tick(); t++; end
    check("wait_top", t < 20, 1);
    check("top_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    t = 0;
    while (!inst_valid_o && t < 20) begin tick(); t++; end
    check("wait_wrap", t < 20, 1);
    check("wrap_pc", pc_o, 32'h0);

    // Random traffic
    rand_lat      = 1'b1;
    base_consumed = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      tick();
      stall_i       = ($urandom_range(9, 0) < 3);
      jump_enable_i = ($urandom_range(99, 0) < 3);
      jump_pc_i     = (32'($urandom_range(127, 0)) << 2) | 32'($urandom_range(3, 0));
    end
    tick();
    stall_i       = 1'b0;
    jump_enable_i = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("random_progress", (n_consumed - base_consumed) > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
